// File: rtl/mem_wait_ctrl.sv
// mem_wait_ctrl: word-addressed data memory with a valid/ready request port,
// a configurable access latency and sub-word little-endian accesses.
// Optional build macro: MEM_STATS_EN adds request/error statistics counters.
module mem_wait_ctrl #(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
`ifdef MEM_STATS_EN
    ,
    output logic [31:0] stat_req_cnt,
    output logic [15:0] stat_err_cnt
`endif
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [31:0] cnt;
    logic [31:0] mem [DEPTH];

    logic        lat_we;
    logic [31:0] lat_addr;
    logic [1:0]  lat_size;
    logic        lat_unsigned;
    logic [31:0] lat_wdata;

    logic        cur_we;
    logic [31:0] cur_addr;
    logic [1:0]  cur_size;
    logic        cur_unsigned;
    logic [31:0] cur_wdata;

    logic        accept;
    logic        commit;
    logic [31:0] idx;
    logic        cur_err;
    logic [31:0] rword;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic [3:0]  wmask;
    logic [31:0] wword;

    assign accept = req_valid && (state == IDLE);

    // With LATENCY==1 the commit edge is also the accept edge, so the
    // request is taken straight from the inputs; otherwise from the latch.
    assign commit = !rst && (((state == IDLE) && req_valid && (LATENCY == 1)) ||
                             ((state == WAIT) && (cnt == '0)));

    // Select the request being committed: live inputs in IDLE, latched copy later
    always_comb begin
        if (state == IDLE) begin
            cur_we       = req_we;
            cur_addr     = req_addr;
            cur_size     = req_size;
            cur_unsigned = req_unsigned;
            cur_wdata    = req_wdata;
        end else begin
            cur_we       = lat_we;
            cur_addr     = lat_addr;
            cur_size     = lat_size;
            cur_unsigned = lat_unsigned;
            cur_wdata    = lat_wdata;
        end
    end

    // Address decode, error check, load extraction and store lane generation
    always_comb begin
        idx     = (cur_addr - BASE_ADDR) >> 2;
        cur_err = (idx >= DEPTH) ||
                  (cur_size == 2'd3) ||
                  ((cur_size == 2'd1) && cur_addr[0]) ||
                  ((cur_size == 2'd2) && (cur_addr[1:0] != 2'b00));
        rword   = mem[idx[AW-1:0]];
        ld_byte = rword[{cur_addr[1:0], 3'b000} +: 8];
        ld_half = rword[{cur_addr[1], 4'b0000} +: 16];
        ld_data = rword;
        wmask   = 4'b1111;
        wword   = cur_wdata;
        case (cur_size)
            2'd0: begin
                ld_data = cur_unsigned ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
                wmask   = 4'b0001 << cur_addr[1:0];
                wword   = {4{cur_wdata[7:0]}};
            end
            2'd1: begin
                ld_data = cur_unsigned ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
                wmask   = 4'b0011 << {cur_addr[1], 1'b0};
                wword   = {2{cur_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Byte-lane store into the array on the commit edge; contents survive reset
    always_ff @(posedge clk) begin
        if (commit && cur_we && !cur_err) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wmask[i]) begin
                    mem[idx[AW-1:0]][8*i +: 8] <= wword[8*i +: 8];
                end
            end
        end
    end

    // Control FSM with registered handshake/response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            req_ready    <= 1'b1;
            busy         <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
            lat_we       <= 1'b0;
            lat_addr     <= '0;
            lat_size     <= '0;
            lat_unsigned <= 1'b0;
            lat_wdata    <= '0;
`ifdef MEM_STATS_EN
            stat_req_cnt <= '0;
            stat_err_cnt <= '0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            if (commit) begin
                rsp_valid <= 1'b1;
                rsp_err   <= cur_err;
                rsp_rdata <= (cur_err || cur_we) ? '0 : ld_data;
`ifdef MEM_STATS_EN
                if (cur_err) stat_err_cnt <= stat_err_cnt + 16'd1;
`endif
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_we       <= req_we;
                        lat_addr     <= req_addr;
                        lat_size     <= req_size;
                        lat_unsigned <= req_unsigned;
                        lat_wdata    <= req_wdata;
                        req_ready    <= 1'b0;
                        busy         <= 1'b1;
`ifdef MEM_STATS_EN
                        stat_req_cnt <= stat_req_cnt + 32'd1;
`endif
                        if (LATENCY == 1) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= LATENCY - 2;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) state <= RESP;
                    else           cnt   <= cnt - 32'd1;
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wait_ctrl.sv
// Testbench for mem_wait_ctrl: scoreboard of expected responses, one task per scenario.
module tb_mem_wait_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0, rst4 = 1'b0;
    logic        req_valid = 1'b0, req_valid4 = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [1:0]  req_size = '0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_err, busy;
    logic [31:0] rsp_rdata;
    logic        req_ready4, rsp_valid4, rsp_err4, busy4;
    logic [31:0] rsp_rdata4;
`ifdef MEM_STATS_EN
    logic [31:0] stat_req_cnt, stat_req_cnt4;
    logic [15:0] stat_err_cnt, stat_err_cnt4;
`endif

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mem_wait_ctrl #(.DEPTH(1024), .LATENCY(2), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
`ifdef MEM_STATS_EN
        , .stat_req_cnt(stat_req_cnt), .stat_err_cnt(stat_err_cnt)
`endif
    );

    mem_wait_ctrl #(.DEPTH(1024), .LATENCY(4), .BASE_ADDR(32'h0)) dut4 (
        .clk(clk), .rst(rst4), .req_valid(req_valid4), .req_ready(req_ready4),
        .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid4), .rsp_rdata(rsp_rdata4), .rsp_err(rsp_err4), .busy(busy4)
`ifdef MEM_STATS_EN
        , .stat_req_cnt(stat_req_cnt4), .stat_err_cnt(stat_err_cnt4)
`endif
    );

    // Drive one request into the selected instance and collect its response.
    // lat is the number of cycles from the accept cycle to rsp_valid, -1 on timeout.
    task automatic run_req(input bit sel4, input logic we, input logic [31:0] addr,
                           input logic [1:0] size, input logic uns, input logic [31:0] wd,
                           output logic [31:0] rd, output logic er, output int lat);
        int guard = 0;
        @(negedge clk);
        while (!(sel4 ? req_ready4 : req_ready) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        req_we = we; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wd;
        if (sel4) req_valid4 = 1'b1;
        else      req_valid  = 1'b1;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_valid4 = 1'b0;
        lat = -1;
        rd  = 'x;
        er  = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (sel4 ? rsp_valid4 : rsp_valid) begin
                lat = k;
                rd  = sel4 ? rsp_rdata4 : rsp_rdata;
                er  = sel4 ? rsp_err4 : rsp_err;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; rst4 = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_size = 2'd2;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0; rst4 = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        total += 5;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
        if (rsp_err !== 1'b0)   begin bad++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
    endtask

    task automatic test_store_load;
        logic [31:0] rd;
        logic er;
        int lat;
        exp_t e;
        sbq.push_back('{err: 1'b0, rdata: 32'h0});
        run_req(1'b0, 1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, rd, er, lat);
        e = sbq.pop_front();
        total += 3;
        if (lat !== 2)       begin bad++; $display("FAIL sw_latency: got %0d want 2", lat); end
        if (er !== e.err)    begin bad++; $display("FAIL sw_err: got %b want %b", er, e.err); end
        if (rd !== e.rdata)  begin bad++; $display("FAIL sw_rdata: got %h want %h", rd, e.rdata); end
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0) begin bad++; $display("FAIL sw_strobe_width: got %b want 0", rsp_valid); end
        sbq.push_back('{err: 1'b0, rdata: 32'hDEADBEEF});
        run_req(1'b0, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0, rd, er, lat);
        e = sbq.pop_front();
        total += 3;
        if (lat !== 2)       begin bad++; $display("FAIL lw_latency: got %0d want 2", lat); end
        if (er !== e.err)    begin bad++; $display("FAIL lw_err: got %b want %b", er, e.err); end
        if (rd !== e.rdata)  begin bad++; $display("FAIL lw_rdata: got %h want %h", rd, e.rdata); end
    endtask

    task automatic test_subword;
        logic        t_we   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] t_addr [5] = '{32'h13, 32'h13, 32'h12, 32'h11, 32'h10};
        logic [1:0]  t_size [5] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd2};
        logic        t_uns  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] t_wd   [5] = '{32'h0, 32'h0, 32'h0, 32'h55, 32'h0};
        logic [31:0] t_exp  [5] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0, 32'hDEAD55EF};
        logic [31:0] rd;
        logic er;
        int lat;
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            sbq.push_back('{err: 1'b0, rdata: t_exp[i]});
            run_req(1'b0, t_we[i], t_addr[i], t_size[i], t_uns[i], t_wd[i], rd, er, lat);
            e = sbq.pop_front();
            total += 2;
            if (lat !== 2 || er !== e.err)
                begin bad++; $display("FAIL subword%0d_status: got lat=%0d err=%b want lat=2 err=%b", i, lat, er, e.err); end
            if (rd !== e.rdata)
                begin bad++; $display("FAIL subword%0d_rdata: got %h want %h", i, rd, e.rdata); end
        end
    endtask

    task automatic test_errors;
        logic        t_we   [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] t_addr [5] = '{32'h12, 32'h11, 32'h10, 32'h1000, 32'h10};
        logic [1:0]  t_size [5] = '{2'd2, 2'd1, 2'd2, 2'd2, 2'd3};
        logic        t_err  [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [31:0] t_exp  [5] = '{32'h0, 32'h0, 32'hDEAD55EF, 32'h0, 32'h0};
        logic [31:0] rd;
        logic er;
        int lat;
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            sbq.push_back('{err: t_err[i], rdata: t_exp[i]});
            run_req(1'b0, t_we[i], t_addr[i], t_size[i], 1'b0, 32'hA5A5A5A5, rd, er, lat);
            e = sbq.pop_front();
            total += 3;
            if (lat !== 2)      begin bad++; $display("FAIL err%0d_latency: got %0d want 2", i, lat); end
            if (er !== e.err)   begin bad++; $display("FAIL err%0d_flag: got %b want %b", i, er, e.err); end
            if (rd !== e.rdata) begin bad++; $display("FAIL err%0d_rdata: got %h want %h", i, rd, e.rdata); end
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_size = 2'd2; req_unsigned = 1'b0;
        sbq.push_back('{err: 1'b0, rdata: 32'hDEAD55EF});
        @(posedge clk);                       // accept of A, cycle N
        @(negedge clk);                       // cycle N+1
        req_addr = 32'h10; req_size = 2'd0; req_unsigned = 1'b1;
        sbq.push_back('{err: 1'b0, rdata: 32'h000000EF});
        total += 3;
        if (req_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_n1: got %b want 0", req_ready); end
        if (busy !== 1'b1)      begin bad++; $display("FAIL b2b_busy_n1: got %b want 1", busy); end
        if (rsp_valid !== 1'b0) begin bad++; $display("FAIL b2b_rsp_n1: got %b want 0", rsp_valid); end
        @(negedge clk);                       // cycle N+2
        total += 3;
        if (req_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_n2: got %b want 0", req_ready); end
        if (busy !== 1'b1)      begin bad++; $display("FAIL b2b_busy_n2: got %b want 1", busy); end
        if (rsp_valid !== 1'b1) begin bad++; $display("FAIL b2b_rsp_n2: got %b want 1", rsp_valid); end
        e = sbq.pop_front();
        total++;
        if (rsp_rdata !== e.rdata || rsp_err !== e.err)
            begin bad++; $display("FAIL b2b_first_data: got %h/%b want %h/%b", rsp_rdata, rsp_err, e.rdata, e.err); end
        @(negedge clk);                       // cycle N+3, second request accepted at its end
        total += 2;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_n3: got %b want 1", req_ready); end
        if (rsp_valid !== 1'b0) begin bad++; $display("FAIL b2b_rsp_n3: got %b want 0", rsp_valid); end
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);                       // cycle N+4
        total++;
        if (rsp_valid !== 1'b0 || busy !== 1'b1)
            begin bad++; $display("FAIL b2b_n4: got rsp=%b busy=%b want rsp=0 busy=1", rsp_valid, busy); end
        @(negedge clk);                       // cycle N+5
        e = sbq.pop_front();
        total++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_err !== e.err)
            begin bad++; $display("FAIL b2b_second: got v=%b %h/%b want v=1 %h/%b", rsp_valid, rsp_rdata, rsp_err, e.rdata, e.err); end
    endtask

    task automatic test_reset_in_wait;
        logic [31:0] rd;
        logic er;
        int lat;
        int guard = 0;
        bit seen = 1'b0;
        exp_t e;
        sbq.push_back('{err: 1'b0, rdata: 32'h0});
        run_req(1'b1, 1'b1, 32'h20, 2'd2, 1'b0, 32'hCAFEF00D, rd, er, lat);
        e = sbq.pop_front();
        total++;
        if (lat !== 4 || er !== e.err || rd !== e.rdata)
            begin bad++; $display("FAIL lat4_store: got lat=%0d err=%b rd=%h want lat=4 err=%b rd=%h", lat, er, rd, e.err, e.rdata); end
        @(negedge clk);
        while (!req_ready4 && guard < 20) begin @(negedge clk); guard++; end
        req_we = 1'b1; req_addr = 32'h20; req_size = 2'd2; req_wdata = 32'h12345678;
        req_valid4 = 1'b1;
        @(posedge clk);
        #1 req_valid4 = 1'b0;
        @(negedge clk);                       // first WAIT cycle
        total++;
        if (busy4 !== 1'b1) begin bad++; $display("FAIL lat4_busy_wait: got %b want 1", busy4); end
        rst4 = 1'b1;
        @(posedge clk);
        #1 rst4 = 1'b0;
        @(negedge clk);
        total++;
        if (busy4 !== 1'b0 || req_ready4 !== 1'b1)
            begin bad++; $display("FAIL lat4_after_rst: got busy=%b ready=%b want busy=0 ready=1", busy4, req_ready4); end
        for (int k = 0; k < 8; k++) begin
            if (rsp_valid4) seen = 1'b1;
            @(negedge clk);
        end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL lat4_dropped_rsp: got rsp_valid seen=%b want 0", seen); end
        sbq.push_back('{err: 1'b0, rdata: 32'hCAFEF00D});
        run_req(1'b1, 1'b0, 32'h20, 2'd2, 1'b0, 32'h0, rd, er, lat);
        e = sbq.pop_front();
        total++;
        if (lat !== 4 || er !== e.err || rd !== e.rdata)
            begin bad++; $display("FAIL lat4_reload: got lat=%0d err=%b rd=%h want lat=4 err=%b rd=%h", lat, er, rd, e.err, e.rdata); end
    endtask

`ifdef MEM_STATS_EN
    task automatic test_stats;
        @(negedge clk);
        total += 2;
        if (stat_req_cnt !== 32'd14) begin bad++; $display("FAIL stat_req_cnt: got %0d want 14", stat_req_cnt); end
        if (stat_err_cnt !== 16'd4)  begin bad++; $display("FAIL stat_err_cnt: got %0d want 4", stat_err_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_store_load();
        test_subword();
        test_errors();
        test_back_to_back();
        test_reset_in_wait();
`ifdef MEM_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_wait_ctrl.md
Name: mem_wait_ctrl

Overview:
- Parametrised word-addressed data memory with a valid/ready request handshake and a configurable access latency.
- Replaces the fixed single-cycle memory path in the multicycle CPU so the control FSM can stall on memory.
- Adds sub-word access (byte/half/word, signed/unsigned loads), alignment and range checking, and a one-cycle response strobe.
- Little-endian.

Parameters:
- DEPTH, 1024, number of 32-bit words in the array.
- LATENCY, 2, cycles from request accept to rsp_valid; legal values are ≥1.
- BASE_ADDR, 32'h0000_0000, byte address of word 0.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal and returns an error
- req_unsigned  in  1  zero-extend load result (LBU/LHU)
- req_wdata  in  32  store data, right-aligned (bits [7:0] for byte, [15:0] for half)
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned, out-of-range or illegal-size access; qualified by rsp_valid
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset: clk and rst are one clock; reset is synchronous and active-high. Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0. Memory contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- req_ready = (state==IDLE). A request is accepted in a cycle where req_valid && req_ready. On accept, all req_* fields are latched internally; the inputs are don't-care afterwards.
- IDLE→RESP on accept when LATENCY==1.
- IDLE→WAIT on accept when LATENCY>1; cnt loads LATENCY-2.
- WAIT: cnt decrements each cycle; WAIT→RESP when cnt==0.
- RESP→IDLE unconditionally. rsp_valid=1 only in RESP, so it rises exactly LATENCY cycles after the accept cycle.
- Throughput: one request per LATENCY+1 cycles. No request is accepted during WAIT or RESP.
- Error check, evaluated on the latched request:
  - size 1 with addr[0]=1 is an error.
  - size 2 with addr[1:0]≠0 is an error.
  - size 3 is an error.
  - Word index (addr-BASE_ADDR)>>2 ≥ DEPTH is an error; an address below BASE_ADDR wraps to a large index and is therefore also an error.
- Commit happens on the edge entering RESP:
  - Error: no write, rsp_rdata←0, rsp_err←1.
  - Store: byte lanes selected by addr[1:0]/size are written; all other lanes are preserved. rsp_rdata←0, rsp_err←0.
  - Load: the addressed byte/half/word is shifted to bit 0, then sign-extended (req_unsigned=0) or zero-extended (req_unsigned=1). req_unsigned is ignored for word loads.
- rsp_rdata and rsp_err hold their values until the next commit.
- rst asserted in WAIT or RESP: the FSM returns to IDLE on that edge and the pending request is dropped. If the request had not yet committed, there is no write and no rsp_valid.
- rst and req_valid in the same cycle: reset wins and the request is not accepted.

Optional Feature:
- MEM_STATS_EN defined: adds output ports stat_req_cnt (32 bits, accepted requests) and stat_err_cnt (16 bits, responses with rsp_err=1).
  - Both counters clear on rst.
  - Both increment by 1 on the respective event and wrap at the maximum value.
- MEM_STATS_EN undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst=1 for 2 cycles, then release → req_ready=1, busy=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- SW 0xDEADBEEF to 0x10, accepted in cycle N → rsp_valid=1 only in cycle N+2, rsp_err=0. Then LW 0x10 → rsp_rdata=0xDEADBEEF.
- After the previous store:
  - LB 0x13 → 0xFFFFFFDE
  - LBU 0x13 → 0x000000DE
  - LH 0x12 → 0xFFFFDEAD
  - SB 0x55 to 0x11, then LW 0x10 → 0xDEAD55EF
- Errors:
  - LW 0x12 → rsp_err=1, rsp_rdata=0
  - SH to 0x11 → rsp_err=1, and LW 0x10 is unchanged
  - LW 0x1000 with DEPTH=1024 → rsp_err=1
- Hold req_valid high continuously → req_ready=0 in cycles N+1..N+2; the second request is accepted in cycle N+3; busy is high in cycles N+1..N+2.
- SW 0x12345678 to 0x20 at LATENCY=4, with rst pulsed in the first WAIT cycle → no rsp_valid and busy=0 after reset. A subsequent LW 0x20 returns the pre-existing value.
